// File: rtl/lut_cfg_loader_pkg.sv
// Shared types and sizing helpers for the LUT configuration loader.
package lut_cfg_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } state_t;

   // One config bit per entry in each half-LUT, plus the fracture-enable bit.
   function automatic int unsigned cfg_width_of(input int unsigned mem_size);
      return 2 * mem_size + 1;
   endfunction

endpackage

// File: rtl/lut_cfg_loader.sv
// Bit-serial to parallel config loader; commits a full word to the LUT with a one-cycle comb_set.
module lut_cfg_loader
   import lut_cfg_loader_pkg::*;
#(
   parameter int unsigned INPUTS    = 4,
   parameter int unsigned MEM_SIZE  = 2 ** INPUTS,
   parameter int unsigned CFG_WIDTH = cfg_width_of(MEM_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_start,
   input  logic                 cfg_valid,
   input  logic                 cfg_bit,
   output logic                 cfg_ready,
   output logic [CFG_WIDTH-1:0] config_out,
   output logic                 comb_set,
   output logic                 cfg_busy,
   output logic                 cfg_done
);

   localparam int unsigned CNT_W = $clog2(CFG_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_WIDTH - 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] count;
   logic             transfer;

   // A same-cycle cfg_start wins over the offered bit, even the word-completing one.
   assign transfer  = (state == ST_SHIFT) && cfg_valid && !cfg_start;
   assign cfg_ready = (state == ST_SHIFT);
   assign cfg_busy  = (state != ST_IDLE);

   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:   if (cfg_start) next_state = ST_SHIFT;
         ST_SHIFT:  if (transfer && (count == LAST_IDX)) next_state = ST_COMMIT;
         ST_COMMIT: next_state = cfg_start ? ST_SHIFT : ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         count      <= '0;
         config_out <= '0;
         comb_set   <= 1'b0;
         cfg_done   <= 1'b0;
      end else begin
         state    <= next_state;
         // Registered strobe: high for exactly the cycle spent in COMMIT.
         comb_set <= (next_state == ST_COMMIT);
         if (cfg_start) begin
            count      <= '0;
            config_out <= '0;
            cfg_done   <= 1'b0;
         end else if (transfer) begin
            config_out <= {config_out[CFG_WIDTH-2:0], cfg_bit};
            count      <= count + 1'b1;
         end else if (state == ST_COMMIT) begin
            cfg_done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Scoreboard bench for lut_cfg_loader: expected words queued by the driver, popped on comb_set.
module tb_lut_cfg_loader;

   localparam int unsigned W = 33;

   logic         clk = 1'b0;
   logic         rst;
   logic         cfg_start;
   logic         cfg_valid;
   logic         cfg_bit;
   logic         cfg_ready;
   logic [W-1:0] config_out;
   logic         comb_set;
   logic         cfg_busy;
   logic         cfg_done;

   int unsigned  checks   = 0;
   int unsigned  failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] w1, w2, w3, w4;

   lut_cfg_loader #(.INPUTS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_start  (cfg_start),
      .cfg_valid  (cfg_valid),
      .cfg_bit    (cfg_bit),
      .cfg_ready  (cfg_ready),
      .config_out (config_out),
      .comb_set   (comb_set),
      .cfg_busy   (cfg_busy),
      .cfg_done   (cfg_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // comb_set must be high exactly when a word has been queued, and carry that word.
   always @(posedge clk) begin
      #1;
      if (rst === 1'b0) begin
         check("comb_set", W'(comb_set), W'(exp_q.size() != 0));
         if (comb_set && exp_q.size() != 0) check("config_out", config_out, exp_q.pop_front());
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      cfg_start = 1'b1;
      cfg_valid = 1'b0;
      @(posedge clk);
      #1;
      check("done_clr", W'(cfg_done), '0);
      check("ready_shift", W'(cfg_ready), W'(1));
      check("cfg_zero", config_out, '0);
   endtask

   // Sends word bits from MSB down, nbits of them; toggle inserts an idle cycle before each.
   task automatic send_bits(input logic [W-1:0] word, input int unsigned nbits, input bit toggle);
      for (int i = 0; i < int'(nbits); i++) begin
         @(negedge clk);
         cfg_start = 1'b0;
         if (toggle) begin
            cfg_valid = 1'b0;
            cfg_bit   = ~word[W-1-i];
            @(negedge clk);
         end
         cfg_valid = 1'b1;
         cfg_bit   = word[W-1-i];
         @(posedge clk);
      end
   endtask

   task automatic load(input logic [W-1:0] word, input bit toggle);
      pulse_start();
      send_bits(word, W, toggle);
      exp_q.push_back(word);
   endtask

   task automatic idle_cycles(input int unsigned n);
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_start = 1'b0;
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      w1 = {1'b1, 16'hA5A5, 16'h3C3C};
      w2 = {1'b0, 16'h1234, 16'hFEDC};
      w3 = {1'b1, 16'h0F0F, 16'h8001};
      w4 = {1'b1, 16'hDEAD, 16'hBEEF};
      rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cfg", config_out, '0);
      check("rst_ready", W'(cfg_ready), '0);
      check("rst_busy", W'(cfg_busy), '0);
      check("rst_done", W'(cfg_done), '0);
      @(negedge clk);
      rst = 1'b0;
      // Bits offered while idle must be ignored.
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_ignore", config_out, '0);

      // 1: plain load
      load(w1, 1'b0);
      idle_cycles(3);
      check("t1_done", W'(cfg_done), W'(1));
      check("t1_busy", W'(cfg_busy), '0);
      check("t1_hold", config_out, w1);

      // 2: cfg_valid toggling
      load(w1, 1'b1);
      idle_cycles(3);
      check("t2_done", W'(cfg_done), W'(1));

      // 3: restart on the 33rd bit, then a fresh load without another start
      pulse_start();
      send_bits(w2, W - 1, 1'b0);
      @(negedge clk);
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_bit   = w2[0];
      @(posedge clk);
      #1;
      check("t3_cfg_zero", config_out, '0);
      check("t3_ready", W'(cfg_ready), W'(1));
      check("t3_done", W'(cfg_done), '0);
      send_bits(w3, W, 1'b0);
      exp_q.push_back(w3);
      idle_cycles(3);
      check("t3_done_after", W'(cfg_done), W'(1));

      // 4: reset after 20 bits
      pulse_start();
      send_bits(w4, 20, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t4_ready", W'(cfg_ready), '0);
      check("t4_busy", W'(cfg_busy), '0);
      check("t4_cfg", config_out, '0);
      check("t4_done", W'(cfg_done), '0);

      // 5: back-to-back loads, second start lands in the first COMMIT cycle
      load(w2, 1'b0);
      load(w4, 1'b0);
      idle_cycles(3);
      check("t5_done", W'(cfg_done), W'(1));
      check("t5_hold", config_out, w4);

      idle_cycles(2);
      check("drained", W'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog expired t=%0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
